bitwise_logic_seq: RTL and testbench

- Parametrised multi-function bitwise logic unit. Successor to the fixed 32-bit combinational AND stage.
- Supports four selectable ops.
- Processes operands in SLICE-bit pieces over multiple cycles, so a wide datapath reuses a narrow gate array.
- Uses valid/ready handshakes on input and output, and reports zero/all-ones flags alongside the result.
- Sits between the ALU operand latches and the writeback mux.

---
 rtl/bitwise_logic_pkg.sv | 15 +
 rtl/logic_slice.sv | 30 +++
 rtl/bitwise_logic_seq.sv | 142 ++++++++++++++
 tb/tb_bitwise_logic_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bitwise_logic_pkg.sv
// Shared encodings for the sliced bitwise logic unit: operation codes and FSM states.
package bitwise_logic_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit gate array shared across all slices of an operation,
// with per-slice all-zero / all-one detection.
module logic_slice
    import bitwise_logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a_sl,
    input  logic [SLICE-1:0] b_sl,
    output logic [SLICE-1:0] r_sl,
    output logic             is_zero,
    output logic             is_ones
);

    // Select the bitwise function and classify the resulting slice.
    always_comb begin
        r_sl = {SLICE{1'b0}};
        case (op)
            OP_AND:  r_sl = a_sl & b_sl;
            OP_OR:   r_sl = a_sl | b_sl;
            OP_XOR:  r_sl = a_sl ^ b_sl;
            OP_ANDN: r_sl = a_sl & ~b_sl;
            default: r_sl = a_sl & b_sl;
        endcase
        is_zero = (r_sl == {SLICE{1'b0}});
        is_ones = (r_sl == {SLICE{1'b1}});
    end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic unit: captures operands, evaluates one SLICE per cycle
// through a shared logic_slice, then presents result and zero/ones flags via valid/ready.
module bitwise_logic_seq
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             isZero,
    output logic             isOnes
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("bitwise_logic_seq: SLICE must divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zacc_q, zacc_d;
    logic             oacc_q, oacc_d;
    logic             iszero_q, iszero_d;
    logic             isones_q, isones_d;

    logic [SLICE-1:0] a_sl_s, b_sl_s, r_sl_s;
    logic             sl_zero_s, sl_ones_s;

    assign a_sl_s = a_q[cnt_q*SLICE +: SLICE];
    assign b_sl_s = b_q[cnt_q*SLICE +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op      (op_q),
        .a_sl    (a_sl_s),
        .b_sl    (b_sl_s),
        .r_sl    (r_sl_s),
        .is_zero (sl_zero_s),
        .is_ones (sl_ones_s)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign isZero    = iszero_q;
    assign isOnes    = isones_q;

    // Next-state logic: capture in IDLE, one slice per BUSY cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zacc_d   = zacc_q;
        oacc_d   = oacc_q;
        iszero_d = iszero_q;
        isones_d = isones_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = operandA;
                    b_d     = operandB;
                    cnt_d   = {CW{1'b0}};
                    zacc_d  = 1'b1;
                    oacc_d  = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                result_d[cnt_q*SLICE +: SLICE] = r_sl_s;
                zacc_d = zacc_q & sl_zero_s;
                oacc_d = oacc_q & sl_ones_s;
                if (cnt_q == LAST_SLICE) begin
                    // Flags must include the slice being written this cycle.
                    iszero_d = zacc_q & sl_zero_s;
                    isones_d = oacc_q & sl_ones_s;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 2'b00;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            zacc_q   <= 1'b0;
            oacc_q   <= 1'b0;
            iszero_q <= 1'b0;
            isones_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zacc_q   <= zacc_d;
            oacc_q   <= oacc_d;
            iszero_q <= iszero_d;
            isones_q <= isones_d;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Directed self-checking bench for bitwise_logic_seq (SLICE=8 main instance, SLICE=32 second instance).
module tb_bitwise_logic_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [1:0]  op;
    logic [31:0] operandA, operandB;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        isZero, isOnes;

    logic        w_in_valid, w_in_ready;
    logic [1:0]  w_op;
    logic [31:0] w_a, w_b;
    logic        w_out_valid, w_out_ready;
    logic [31:0] w_result;
    logic        w_isZero, w_isOnes;

    int errors = 0;
    int checks = 0;

    bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .operandA(operandA), .operandB(operandB),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .isZero(isZero), .isOnes(isOnes)
    );

    bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) dut_w (
        .clock(clock), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .operandA(w_a), .operandB(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .isZero(w_isZero), .isOnes(w_isOnes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid, counting edges since the accept edge.
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r,
                          input logic exp_z, input logic exp_o);
        op = o; operandA = a; operandB = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_done(tag, 4);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_zero"}, {31'd0, isZero}, {31'd0, exp_z});
        chk({tag, "_ones"}, {31'd0, isOnes}, {31'd0, exp_o});
        tick();
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; op = 2'b00; operandA = 32'd0; operandB = 32'd0;
        out_ready = 1'b0;
        w_in_valid = 1'b0; w_op = 2'b00; w_a = 32'd0; w_b = 32'd0; w_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, isZero}, 32'd0);
        chk("rst_ones", {31'd0, isOnes}, 32'd0);
        reset_n = 1'b1;
        tick();

        run_op("t1_and", 2'b00, 32'hF0F01234, 32'hFF0000FF, 32'hF0000034, 1'b0, 1'b0);
        run_op("t2_xor", 2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0);
        run_op("t2_or", 2'b01, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b1);

        // Backpressure: hold DONE for 6 cycles while a second request waits.
        op = 2'b11; operandA = 32'hFFFFFFFF; operandB = 32'h0F0F0F0F;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        op = 2'b00; operandA = 32'hA5A5A5A5; operandB = 32'h0F0F0F0F;
        wait_done("t3_andn", 4);
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold_result", result, 32'hF0F0F0F0);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t3_release_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("t3_second_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_done("t3_second", 4);
        chk("t3_second_result", result, 32'h05050505);
        tick();

        // Operand/op changes during BUSY must not affect the captured request.
        op = 2'b00; operandA = 32'h12345678; operandB = 32'hFFFFFFFF;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op = 2'(i + 1); operandA = 32'h0 - 32'(i); operandB = 32'h00FF00FF ^ 32'(i);
            tick();
        end
        op = 2'b10; operandA = 32'hFFFFFFFF; operandB = 32'h0;
        wait_done("t4_and", 1);
        chk("t4_result", result, 32'h12345678);
        chk("t4_zero", {31'd0, isZero}, 32'd0);
        tick();

        // Reset mid-operation after two slices.
        op = 2'b01; operandA = 32'hFFFFFFFF; operandB = 32'hFFFFFFFF;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_result", result, 32'd0);
        chk("t5_rst_zero", {31'd0, isZero}, 32'd0);
        chk("t5_rst_ones", {31'd0, isOnes}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        run_op("t5_or", 2'b01, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);

        // Single-slice instance: one-cycle latency.
        w_op = 2'b10; w_a = 32'hAAAAAAAA; w_b = 32'h55555555;
        w_in_valid = 1'b1; w_out_ready = 1'b0;
        tick();
        w_in_valid = 1'b0;
        chk("t6_busy_valid", {31'd0, w_out_valid}, 32'd0);
        tick();
        chk("t6_valid", {31'd0, w_out_valid}, 32'd1);
        chk("t6_result", w_result, 32'hFFFFFFFF);
        chk("t6_ones", {31'd0, w_isOnes}, 32'd1);
        chk("t6_zero", {31'd0, w_isZero}, 32'd0);
        w_out_ready = 1'b1;
        tick();
        chk("t6_idle_ready", {31'd0, w_in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
